// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver feeding a small byte FIFO that drives the core's read port.
// Optional saturating error counter on port err_count, enabled by UART_RX_ERRCNT_EN.
module uart_rx_buf #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DEPTH        = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       rx,
    input  logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data
`ifdef UART_RX_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic          rxs_q;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic          expired;
    logic          stop_sample;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;

    // Synchronizer flops reset high so reset never looks like a start edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_q   <= rxs;
        end
    end

    assign expired     = (bit_cnt == '0);
    assign stop_sample = (state == STOP) && expired;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop   = rd_ready && !empty;
    assign push  = stop_sample && rxs && (!full || pop);

    // Frame FSM; only a falling edge leaves IDLE, so a held-low break cannot retrigger.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rxs_q && !rxs) begin
                        bit_cnt <= HALF_LOAD;
                        state   <= START;
                    end
                end
                START: begin
                    if (expired) begin
                        bit_cnt <= BIT_LOAD;
                        if (!rxs) begin
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (expired) begin
                        bit_cnt   <= BIT_LOAD;
                        shift_reg <= {rxs, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (expired) begin
                        bit_cnt <= BIT_LOAD;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N && push) begin
            mem[wr_ptr[AW-1:0]] <= shift_reg;
        end
    end

    // Pointer wrap bits distinguish full from empty when the indices match.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

`ifdef UART_RX_ERRCNT_EN
    logic err_event;

    // Framing error (stop bit low) or overrun (full with no pop) at the stop sample.
    assign err_event = stop_sample && (!rxs || (full && !pop));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_count <= 8'h00;
        end else if (err_event && (err_count != 8'hFF)) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    // Without the counter, framing errors and overruns simply drop the byte.
`endif

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: directed test-plan steps plus randomized frames
// checked against a queue-based model of the receive FIFO and error count.
module tb_uart_rx_buf;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       rx;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
`ifdef UART_RX_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_q[$];
    int         model_err = 0;

    uart_rx_buf #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .rx      (rx),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
`ifdef UART_RX_ERRCNT_EN
        .err_count(err_count),
`endif
        .rd_data (rd_data)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_value(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag);
        logic [7:0] exp_data;
        exp_data = (model_q.size() > 0) ? model_q[0] : 8'h00;
        check_value({tag, ".valid"}, {7'd0, rd_valid}, {7'd0, model_q.size() > 0});
        check_value({tag, ".data"}, rd_data, exp_data);
`ifdef UART_RX_ERRCNT_EN
        check_value({tag, ".err"}, err_count, 8'(model_err));
`endif
    endtask

    task automatic model_error();
        if (model_err < 255) model_err++;
    endtask

    task automatic apply_reset();
        rx       = 1'b1;
        rd_ready = 1'b0;
        RST_N    = 1'b0;
        tick(2);
        RST_N = 1'b1;
        model_q.delete();
        model_err = 0;
        check_output("reset");
        tick(4);
    endtask

    // One full 8N1 frame; optionally pops during the stop-bit sample cycle.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit, input logic pop_at_stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB / 2 + 2);
        check_output("stop_cycle");
        if (pop_at_stop) rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        if (pop_at_stop && model_q.size() > 0) void'(model_q.pop_front());
        if (!stop_bit) begin
            model_error();
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back(data);
        end else begin
            model_error();
        end
        check_output("post_stop");
        tick(CPB - CPB / 2 - 3);
    endtask

    task automatic pop_check(input string tag);
        check_output({tag, ".pre"});
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
        check_output({tag, ".post"});
    endtask

    initial begin
        logic [7:0] b;
        logic       stop_ok;
        logic       pas;

        rx       = 1'b1;
        rd_ready = 1'b0;
        RST_N    = 1'b0;
        tick(1);
        apply_reset();

        $display("[TB] single byte 0x55");
        apply_stimulus(8'h55, 1'b1, 1'b0);
        pop_check("pop55");

        $display("[TB] fill FIFO then overrun");
        apply_stimulus(8'h01, 1'b1, 1'b0);
        apply_stimulus(8'h80, 1'b1, 1'b0);
        apply_stimulus(8'hFF, 1'b1, 1'b0);
        apply_stimulus(8'h3C, 1'b1, 1'b0);
        check_output("full");
        apply_stimulus(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop_check("drain_overrun");

        $display("[TB] full with pop on stop sample");
        apply_reset();
        apply_stimulus(8'h01, 1'b1, 1'b0);
        apply_stimulus(8'h80, 1'b1, 1'b0);
        apply_stimulus(8'hFF, 1'b1, 1'b0);
        apply_stimulus(8'h3C, 1'b1, 1'b0);
        apply_stimulus(8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) pop_check("drain_simul");

        $display("[TB] framing error and break");
        apply_reset();
        apply_stimulus(8'h42, 1'b0, 1'b0);
        tick(40 * CPB);
        check_output("break");
        rx = 1'b1;
        tick(CPB);
        apply_stimulus(8'h42, 1'b1, 1'b0);
        pop_check("after_break");

        $display("[TB] start glitch");
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(2 * CPB);
        check_output("glitch");

        $display("[TB] reset mid-frame");
        apply_stimulus(8'h11, 1'b1, 1'b0);
        apply_stimulus(8'h22, 1'b1, 1'b0);
        check_output("two_queued");
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
        rx = 1'b0;
        tick(5);
        rx    = 1'b1;
        RST_N = 1'b0;
        tick(1);
        RST_N = 1'b1;
        model_q.delete();
        model_err = 0;
        check_output("mid_reset");
        tick(CPB);
        apply_stimulus(8'h7E, 1'b1, 1'b0);
        pop_check("after_reset");

        $display("[TB] randomized frames");
        for (int n = 0; n < 16; n++) begin
            b       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 7) != 0);
            pas     = ($urandom_range(0, 3) == 0);
            apply_stimulus(b, stop_ok, pas);
            if (!stop_ok) begin
                rx = 1'b1;
                tick(CPB);
            end
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) pop_check("rand_pop");
            tick(int'($urandom_range(0, 20)));
        end
        for (int i = 0; i <= DEPTH; i++) pop_check("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_buf.md
# uart_rx_buf

Serial UART receiver with a small byte FIFO that feeds the core's UART read interface. It samples an asynchronous 8N1 `rx` line and deserializes bytes. It then presents them as the 9-bit `{valid, data}` word on `ext_uart_read_out`, consuming a byte when the core drives `ext_uart_read_arg` (ready) high. It replaces the tied-off `valid=0, data=0` read path in the top-level wrapper.

## Interface
- `CLKS_PER_BIT`, 217: CLK cycles per UART bit (25 MHz / 115200); legal range ≥ 4.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CLK` input 1: the single clock; all state updates on rising edge.
- `RST_N` input 1: reset is synchronous and active-low.
- `rx` input 1: asynchronous serial line; idle high.
- `rd_ready` input 1: core pop request; connects to `ext_uart_read_arg`.
- `rd_valid` output 1: FIFO non-empty; bit 8 of `ext_uart_read_out`.
- `rd_data` output 8: FIFO head byte; bits 7:0 of `ext_uart_read_out`.
- `err_count` output 8: present only with `UART_RX_ERRCNT_EN`; saturating error count.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1). In this section, `rxs` means the synchronized value and `rxs_q` means the previous `rxs`.
- Bit timer: counter of width `$clog2(CLKS_PER_BIT)`. Expiry means count == 0; on expiry the counter reloads `CLKS_PER_BIT-1`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge (`rxs_q=1`, `rxs=0`), load the counter with `CLKS_PER_BIT/2-1` and go to START. A line held low (break) never re-triggers.
  - START: on expiry, sample `rxs`. If 0, go to DATA with bit index 0. If 1, treat as a glitch and go to IDLE with nothing pushed.
  - DATA: on each expiry, shift `rxs` in LSB-first. After the 8th bit, go to STOP.
  - STOP: on expiry, sample `rxs`:
    - If 1 and FIFO not full (or full with a pop this cycle), push the byte.
    - If 1 and FIFO full with no pop this cycle, drop the byte (overrun).
    - If 0, drop the byte (framing error).
    - In all three cases, go to IDLE.
- FIFO: `DEPTH` entries, read/write pointers with an extra wrap bit.
  - Empty when the pointers are fully equal.
  - Full when the indices are equal and the wrap bits differ.
- Outputs:
  - `rd_valid` = not empty.
  - `rd_data` = head entry when `rd_valid`, else 8'h00.
- Pop: occurs when `rd_ready && rd_valid`. `rd_ready` while empty is ignored.
- Push and pop in the same cycle: both take effect. When full, the pop frees the slot and the push is accepted.
- There is no bypass path: a byte pushed while the FIFO is empty is not visible in the same cycle.
- Reset: FSM goes to IDLE, pointers to 0, shift register to 0. `rd_valid=0`, `rd_data=8'h00`, `err_count=0`. A frame in progress when reset asserts is discarded.

## Timing
- Start-edge detect is 2–3 cycles after the `rx` fall (synchronizer delay).
- Sampling points fall at mid-bit, ±1 cycle: START + `CLKS_PER_BIT/2`, then every `CLKS_PER_BIT`.
- Push occurs on the stop-bit mid-sample cycle. `rd_valid` rises on the next cycle.
- `rd_valid` and `rd_data` are combinational from registered state only; there is no path from `rd_ready` to either.
- Back-to-back frames:
  - IDLE is reached at stop-bit mid-sample.
  - The next start edge is accepted from the following cycle.
  - Sustained line rate is supported with no byte loss while the core keeps the FIFO from filling.

## Configuration
- `UART_RX_ERRCNT_EN` defined:
  - Port `err_count[7:0]` exists.
  - It increments by 1 on each framing error or overrun drop (at most one per cycle) and saturates at 255.
  - A glitch rejected in START does not count.
- Not defined: the port and counter are absent; errors are silently dropped.

## Test plan
- Byte 0x55 at `CLKS_PER_BIT=16`, `rd_ready=0` → `rd_valid=1` one cycle after the stop-bit sample with `rd_data=8'h55`. One cycle of `rd_ready=1` → `rd_valid=0`, `rd_data=8'h00`.
- Bytes 0x01, 0x80, 0xFF, 0x3C back to back, no pops (`DEPTH=4`) → FIFO full. Then a 5th byte 0xA5 → dropped, `err_count=1`. Pops return 01, 80, FF, 3C in order.
- FIFO full and `rd_ready=1` on the same cycle as the 0xA5 stop sample → 0xA5 accepted, `err_count=0`. Pops return 80, FF, 3C, A5.
- Frame 0x42 with the stop bit driven 0 → no push, `err_count=1`. `rx` held low for 40 bit times → no further frames. `rx` high then frame 0x42 → 0x42 received.
- `rx` low pulse of 3 cycles while idle → START rejects it, FIFO unchanged, `err_count=0`.
- `RST_N=0` for 1 cycle mid-DATA with 2 bytes queued → next cycle `rd_valid=0`, `rd_data=8'h00`, `err_count=0`. The next full frame 0x7E is received correctly.
